// File: rtl/oven_pkg.sv
// Shared state type, cook-time constants and selection decoding for the oven countdown timer.
package oven_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        PAUSE,
        DONE
    } timer_state_t;

    localparam int REM_W = 8;

    localparam logic [REM_W-1:0] T30  = 8'd30;
    localparam logic [REM_W-1:0] T60  = 8'd60;
    localparam logic [REM_W-1:0] T120 = 8'd120;

    // Zero means the selection is not exactly one-hot, which no valid cook time uses.
    function automatic logic [REM_W-1:0] sel_time(input logic sel_30,
                                                  input logic sel_60,
                                                  input logic sel_120);
        logic [REM_W-1:0] t;
        case ({sel_120, sel_60, sel_30})
            3'b001:  t = T30;
            3'b010:  t = T60;
            3'b100:  t = T120;
            default: t = '0;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/oven_prescaler.sv
// Divides clk down to one tick per countdown second; holds its count while en is low.
module oven_prescaler #(
    parameter int unsigned TICKS_PER_SEC = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int unsigned CNT_W = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TICKS_PER_SEC - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign tick = en && (cnt_q == LAST);

    // NOTE: every path assigns cnt_d a default first, so no latch is inferred.
    always_comb begin
        cnt_d = cnt_q;
        if (clr || tick) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/oven_timer.sv
// Oven cook-time countdown: loads 30/60/120 s, counts down with pause/resume, pulses timeout.
module oven_timer
    import oven_pkg::*;
#(
    parameter int unsigned TICKS_PER_SEC = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_count,
    input  logic             stop_count,
    input  logic             abort,
    input  logic             s30,
    input  logic             s60,
    input  logic             s120,
    input  logic             time_set,
    output logic             timeout,
    output logic [REM_W-1:0] remaining,
    output logic             running,
    output logic             paused,
    output logic             sel_err
);

    timer_state_t     state_q, state_d;
    logic [REM_W-1:0] rem_q, rem_d;
    logic             sel_err_q, sel_err_d;
    logic [REM_W-1:0] load_time;
    logic             load_req;
    logic             tick;
    logic             ps_en;
    logic             ps_clr;

    assign load_time = sel_time(s30, s60, s120);
    assign load_req  = start_count && !stop_count;

    // A stop in RUN freezes the prescaler on that very edge, so a coincident tick is lost.
    assign ps_en  = (state_q == RUN) && !stop_count && !abort;
    assign ps_clr = abort || (state_q == IDLE) || (state_q == DONE);

    oven_prescaler #(
        .TICKS_PER_SEC(TICKS_PER_SEC)
    ) u_prescaler (
        .clk  (clk),
        .reset(reset),
        .en   (ps_en),
        .clr  (ps_clr),
        .tick (tick)
    );

    always_comb begin
        state_d   = state_q;
        rem_d     = rem_q;
        sel_err_d = 1'b0;
        if (abort) begin
            state_d = IDLE;
            rem_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (load_req) begin
                        if (time_set && (load_time != '0)) begin
                            rem_d   = load_time;
                            state_d = RUN;
                        end else begin
                            sel_err_d = 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (stop_count) begin
                        state_d = PAUSE;
                    end else if (tick) begin
                        if (rem_q <= REM_W'(1)) begin
                            rem_d   = '0;
                            state_d = DONE;
                        end else begin
                            rem_d = rem_q - REM_W'(1);
                        end
                    end
                end
                PAUSE: begin
                    if (load_req) begin
                        state_d = RUN;
                    end
                end
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            rem_q     <= '0;
            sel_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            rem_q     <= rem_d;
            sel_err_q <= sel_err_d;
        end
    end

    assign timeout   = (state_q == DONE);
    assign running   = (state_q == RUN);
    assign paused    = (state_q == PAUSE);
    assign remaining = rem_q;
    assign sel_err   = sel_err_q;

endmodule

// File: doc/oven_timer.md
OVEN_TIMER -- requirements
Module: oven_timer

Interface
REQ-001 Parameter: TICKS_PER_SEC, default 1, clk cycles per countdown second; legal range 1..2^16.
REQ-002 Port: clk  input  1  the only clock; all state changes on its rising edge.
REQ-003 Port: reset  input  1  asynchronous, active-low reset.
REQ-004 Port: start_count  input  1  level request from ctrl_oven to load and run, or to resume.
REQ-005 Port: stop_count  input  1  level request from ctrl_oven to pause the countdown.
REQ-006 Port: abort  input  1  synchronous cancel; return to IDLE without a timeout.
REQ-007 Port: s30 / s60 / s120  input  1 each  one-hot cook-time selection of 30, 60 or 120 s.
REQ-008 Port: time_set  input  1  qualifies the selection as valid.
REQ-009 Port: timeout  output  1  one-cycle pulse to ctrl_oven when the countdown completes.
REQ-010 Port: remaining  output  8  seconds left, unsigned.
REQ-011 Port: running  output  1  high in RUN.
REQ-012 Port: paused  output  1  high in PAUSE.
REQ-013 Port: sel_err  output  1  one-cycle pulse when a load is rejected.

Function
REQ-014 The block SHALL use a Moore FSM with states IDLE, RUN, PAUSE and DONE.
REQ-015 In IDLE, remaining SHALL be 0.
REQ-016 In IDLE with start_count=1, stop_count=0, time_set=1 and exactly one of s30/s60/s120 high, the block SHALL do the following at that edge: load remaining with 30, 60 or 120; clear the prescaler; enter RUN.
REQ-017 In IDLE, the block SHALL reject a start_count=1, stop_count=0 request when the selection is invalid (time_set=0, or zero or several selects high), as follows: stay in IDLE and pulse sel_err for one cycle.
REQ-018 In IDLE, start_count and stop_count both high SHALL leave the block in IDLE with no sel_err.
REQ-019 In RUN, the prescaler SHALL count 0..TICKS_PER_SEC-1; at TICKS_PER_SEC-1 it SHALL wrap to 0 and produce a tick.
REQ-020 On a RUN tick with remaining>1, remaining SHALL decrement by 1.
REQ-021 On a RUN tick with remaining=1, the block SHALL set remaining to 0 and enter DONE; remaining SHALL never wrap below 0.
REQ-022 In RUN, stop_count=1 SHALL enter PAUSE and freeze remaining and the prescaler; a coincident tick SHALL be discarded, so stop has priority.
REQ-023 In PAUSE, start_count=1 with stop_count=0 SHALL resume RUN from the frozen remaining and prescaler values.
REQ-024 In RUN and PAUSE, changes to the time selection SHALL be ignored.
REQ-025 timeout SHALL be high only in DONE; DONE SHALL last exactly one cycle and then return to IDLE.
REQ-026 With TICKS_PER_SEC=1, a load at edge N SHALL make timeout high in the cycle following edge N+T, where T is the selected time.
REQ-027 abort=1 SHALL force IDLE from any state at the next edge: remaining=0, prescaler=0, no timeout; abort has priority over all other inputs.
REQ-028 sel_err and timeout SHALL never be high in the same cycle.

Reset
REQ-029 While reset=0, the block SHALL immediately be in IDLE with remaining=0, prescaler=0, timeout=0, running=0, paused=0 and sel_err=0.
REQ-030 Reset asserted mid-RUN or mid-PAUSE SHALL discard the countdown; no timeout SHALL follow.
REQ-031 After reset deasserts, the first state change SHALL occur on the first rising edge of clk.

Structure
REQ-032 Package oven_pkg SHALL hold timer_state_t (IDLE, RUN, PAUSE, DONE) and the constants T30=30, T60=60, T120=120 and REM_W=8.
REQ-033 The tick generator SHALL be the sub-module oven_prescaler, with ports clk, reset, en, clr and tick, and a counter of width max(1, $clog2(TICKS_PER_SEC)).
REQ-034 All outputs SHALL be registered or decoded from state only.

Verification
REQ-035 The bench SHALL cover: TICKS=1, s30+time_set, start pulse at edge N -> running at N, remaining 30→0, timeout high for exactly one cycle after edge N+30, then IDLE.
REQ-036 The bench SHALL cover: TICKS=1, s60 run, stop_count at remaining=40 for 10 cycles, then start -> remaining holds 40 and paused=1 during the stop, then resumes; timeout arrives 10 cycles later than an uninterrupted run.
REQ-037 The bench SHALL cover: s30 and s60 both high, or time_set=0, plus start -> sel_err high for one cycle, state stays IDLE, remaining=0.
REQ-038 The bench SHALL cover: TICKS=4, s120 -> timeout 480 cycles after the load; a stop coincident with a tick leaves remaining unchanged.
REQ-039 The bench SHALL cover: reset=0 or abort mid-RUN at remaining=17 -> remaining=0, IDLE, and no timeout within the following 200 cycles.
REQ-040 The bench SHALL cover: start and stop both high in IDLE -> no load and no sel_err.
